mem_access: RTL

- Memory-access stage, directly downstream of the execute stage.
- Consumes EX results (ALU result, store data, destination register, exception/PC/delay-slot info) and performs loads/stores over an SRAM-like request/response data bus.
- Sign/zero-extends load data and adds address-error exceptions.
- Stalls upstream while a bus transaction is outstanding; delivers one registered result per instruction to the writeback side.

---
 rtl/mem_access.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access.sv
// Memory-access stage: issues loads/stores on an SRAM-like request/response bus and
// registers one result per instruction. Define MEM_ADDR_CHECK_EN to raise AdEL/AdES.
module mem_access #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [3:0]        mem_op_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] store_data_i,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  input  logic [31:0]       exception_type_i,
  input  logic [31:0]       current_instr_addr_i,
  input  logic              is_in_delayslot_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              data_req_o,
  output logic              data_wr_o,
  output logic [1:0]        data_size_o,
  output logic [ADDR_W-1:0] data_addr_o,
  output logic [DATA_W-1:0] data_wdata_o,
  input  logic              data_addr_ok_i,
  input  logic              data_data_ok_i,
  input  logic [DATA_W-1:0] data_rdata_i,
  output logic              valid_o,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic [31:0]       exception_type_o,
  output logic [ADDR_W-1:0] badvaddr_o,
  output logic [31:0]       current_instr_addr_o,
  output logic              is_in_delayslot_o
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_e;

  state_e            state_q;
  logic [3:0]        op_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic [DATA_W-1:0] req_wdata_q;
  logic [1:0]        req_size_q;
  logic              req_wr_q;
  logic [4:0]        wd_q;
  logic              wreg_q;
  logic [31:0]       pc_q;
  logic              ds_q;

  logic              is_load, is_store, addr_err, accept;
  logic [1:0]        size_d;
  logic [ADDR_W-1:0] req_addr_d, badvaddr_d;
  logic [DATA_W-1:0] req_wdata_d, load_data_d;
  logic [31:0]       exc_d;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    size_d   = 2'd0;
    case (mem_op_i)
      OP_LB, OP_LBU: is_load = 1'b1;
      OP_LH, OP_LHU: begin is_load = 1'b1; size_d = 2'd1; end
      OP_LW:         begin is_load = 1'b1; size_d = 2'd2; end
      OP_SB:         is_store = 1'b1;
      OP_SH:         begin is_store = 1'b1; size_d = 2'd1; end
      OP_SW:         begin is_store = 1'b1; size_d = 2'd2; end
      default: ;
    endcase
  end

  always_comb begin
    req_addr_d = addr_i;
`ifdef MEM_ADDR_CHECK_EN
    addr_err = (is_load | is_store) &&
               ((size_d == 2'd1 && addr_i[0]) || (size_d == 2'd2 && addr_i[1:0] != 2'b00));
`else
    // Without checking, misaligned accesses are silently aligned down to their size.
    addr_err = 1'b0;
    if (size_d == 2'd1)      req_addr_d[0]   = 1'b0;
    else if (size_d == 2'd2) req_addr_d[1:0] = 2'b00;
`endif
    exc_d      = exception_type_i;
    exc_d[4]   = exception_type_i[4] | (addr_err & is_load);
    exc_d[5]   = exception_type_i[5] | (addr_err & is_store);
    badvaddr_d = addr_err ? addr_i : '0;
    case (size_d)
      2'd0:    req_wdata_d = {4{store_data_i[7:0]}};
      2'd1:    req_wdata_d = {2{store_data_i[15:0]}};
      default: req_wdata_d = store_data_i;
    endcase
    accept = valid_i && !flush_i && (is_load | is_store) && !addr_err &&
             (exception_type_i == '0);
  end

  always_comb begin
    case (req_addr_q[1:0])
      2'd0:    ld_byte = data_rdata_i[7:0];
      2'd1:    ld_byte = data_rdata_i[15:8];
      2'd2:    ld_byte = data_rdata_i[23:16];
      default: ld_byte = data_rdata_i[31:24];
    endcase
    ld_half = req_addr_q[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];
    case (op_q)
      OP_LB:   load_data_d = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  load_data_d = {24'd0, ld_byte};
      OP_LH:   load_data_d = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  load_data_d = {16'd0, ld_half};
      OP_LW:   load_data_d = data_rdata_i;
      default: load_data_d = '0;
    endcase
  end

  always_comb begin
    stall_o = 1'b0;
    case (state_q)
      S_IDLE:  stall_o = accept;
      S_REQ:   stall_o = 1'b1;
      S_WAIT:  stall_o = !data_data_ok_i;
      S_DRAIN: stall_o = 1'b1;
      default: stall_o = 1'b0;
    endcase
  end

  assign data_req_o   = (state_q == S_REQ);
  assign data_wr_o    = req_wr_q;
  assign data_size_o  = req_size_q;
  assign data_addr_o  = req_addr_q;
  assign data_wdata_o = req_wdata_q;

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q              <= S_IDLE;
      op_q                 <= '0;
      req_addr_q           <= '0;
      req_wdata_q          <= '0;
      req_size_q           <= '0;
      req_wr_q             <= 1'b0;
      wd_q                 <= '0;
      wreg_q               <= 1'b0;
      pc_q                 <= '0;
      ds_q                 <= 1'b0;
      valid_o              <= 1'b0;
      wd_o                 <= '0;
      wreg_o               <= 1'b0;
      wdata_o              <= '0;
      exception_type_o     <= '0;
      badvaddr_o           <= '0;
      current_instr_addr_o <= '0;
      is_in_delayslot_o    <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            state_q     <= S_REQ;
            op_q        <= mem_op_i;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            req_size_q  <= size_d;
            req_wr_q    <= is_store;
            wd_q        <= wd_i;
            wreg_q      <= wreg_i;
            pc_q        <= current_instr_addr_i;
            ds_q        <= is_in_delayslot_i;
          end else if (valid_i && !flush_i) begin
            valid_o              <= 1'b1;
            wd_o                 <= wd_i;
            wreg_o               <= wreg_i && !is_store && (exc_d == '0);
            wdata_o              <= alu_result_i;
            exception_type_o     <= exc_d;
            badvaddr_o           <= badvaddr_d;
            current_instr_addr_o <= current_instr_addr_i;
            is_in_delayslot_o    <= is_in_delayslot_i;
          end
        end
        S_REQ: begin
          if (data_addr_ok_i) state_q <= flush_i ? S_DRAIN : S_WAIT;
          else if (flush_i)   state_q <= S_IDLE;
        end
        S_WAIT: begin
          if (data_data_ok_i) begin
            state_q <= S_IDLE;
            if (!flush_i) begin
              valid_o              <= 1'b1;
              wd_o                 <= wd_q;
              wreg_o               <= wreg_q && !req_wr_q;
              wdata_o              <= load_data_d;
              exception_type_o     <= '0;
              badvaddr_o           <= '0;
              current_instr_addr_o <= pc_q;
              is_in_delayslot_o    <= ds_q;
            end
          end else if (flush_i) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // The in-flight response still has to be consumed before a new request.
          if (data_data_ok_i) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
